// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32I data memory with sized/sign-extended loads, byte-enable stores,
// a registered 1-cycle response held under backpressure, and fault reporting.
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] read_data,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  localparam int unsigned AW = $clog2(4 * DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] read_data_q, read_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [32:0]   off;
  logic [AW-3:0] idx;
  logic [1:0]    lane;
  logic          accept, illegal, out_range, misal, flt, wr_en;
  logic [1:0]    cause_c;
  logic [3:0]    be;
  logic [31:0]   wdata, word, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // reset_n gates acceptance so nothing is written while reset is held
  assign req_ready = reset_n && ((state_q == IDLE) || resp_ready);
  assign accept    = req_valid && req_ready;

  // 33-bit offset: the borrow bit catches addresses below BASE_ADDR
  assign off  = {1'b0, address} - {1'b0, BASE_ADDR};
  assign idx  = off[AW-1:2];
  assign lane = off[1:0];

  always_comb begin
    illegal   = mem_write ? (funct3 > 3'b010)
                          : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    out_range = |off[32:AW];
    misal     = ((funct3[1:0] == 2'b01) && lane[0]) ||
                ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    if (illegal)        cause_c = 2'd3;
    else if (out_range) cause_c = 2'd2;
    else if (misal)     cause_c = 2'd1;
    else                cause_c = 2'd0;
    flt   = (cause_c != 2'd0);
    wr_en = accept && mem_write && !flt;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = write_data;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    word     = mem[idx];
    byte_sel = word[8*lane +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    if (accept) begin
      state_d     = RESP;
      read_data_d = (!mem_write && !flt) ? load_val : 32'h0;
      fault_d     = flt;
      cause_d     = cause_c;
    end else if ((state_q == RESP) && resp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      read_data_q <= 32'h0;
      fault_q     <= 1'b0;
      cause_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  // Array is deliberately not reset; contents survive reset_n
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign read_data   = read_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule
